pipelined_addsub: RTL

//  Parametrised, pipelined ripple-carry adder/subtractor; successor of the 4-bit combinational adder.

---
 rtl/pipelined_addsub.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into CHUNK-bit slices,
// one register stage per slice, valid/ready handshake with a global advance enable.

module pipelined_addsub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o,
  output logic             cmsb_o
);
  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = cin_i;
    for (int i = 0; i < CHUNK; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c[CHUNK];
  assign cmsb_o = c[CHUNK-1];
endmodule

module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  // Each stage carries the full operand/result word; untouched chunks ride along,
  // which gives the operand skew and result deskew without separate delay lines.
  typedef struct packed {
    logic             sub;
    logic             cy;
    logic             ovf;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stg_t;

  stg_t                    stg_in;
  stg_t [STAGES-1:0]       stg_d, stg_q;
  logic [STAGES-1:0]       vld_q;
  logic [STAGES:0]         vld_pipe;
  logic                    adv;

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;

  assign stg_in = '{sub: sub, cy: sub, ovf: 1'b0, a: a, b: b, s: '0};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stg_t             src;
    logic [CHUNK-1:0] s_chunk;
    logic             co, cm;
    logic [WIDTH-1:0] s_new;

    if (k == 0) begin : g_first
      assign src = stg_in;
    end else begin : g_next
      assign src = stg_q[k-1];
    end

    pipelined_addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .a_i   (src.a[k*CHUNK +: CHUNK]),
      .b_i   (src.b[k*CHUNK +: CHUNK] ^ {CHUNK{src.sub}}),
      .cin_i (src.cy),
      .s_o   (s_chunk),
      .cout_o(co),
      .cmsb_o(cm)
    );

    always_comb begin
      s_new                      = src.s;
      s_new[k*CHUNK +: CHUNK]    = s_chunk;
    end

    // Only the MSB slice's internal carry defines signed overflow.
    assign stg_d[k] = '{sub: src.sub, cy: co,
                        ovf: (k == STAGES-1) ? (cm ^ co) : src.ovf,
                        a: src.a, b: src.b, s: s_new};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
      vld_q <= '0;
    end else if (adv) begin
      stg_q <= stg_d;
      vld_q <= vld_pipe[STAGES-1:0];
    end
  end

  assign sum  = stg_q[STAGES-1].s;
  assign cout = stg_q[STAGES-1].cy;
  assign ovf  = stg_q[STAGES-1].ovf;

  logic unused_bits;
  assign unused_bits = ^{stg_q[STAGES-1].a, stg_q[STAGES-1].b, stg_q[STAGES-1].sub};
endmodule
